// File: rtl/retire_trace_fifo_pkg.sv
// Shared constants for the retirement tracer: record kinds, field widths,
// record bit offsets, tracer FSM states and the retire classifier.
package retire_trace_fifo_pkg;

   localparam int KIND_W = 3;
   localparam int PC_W   = 16;
   localparam int REG_W  = 3;
   localparam int DATA_W = 16;

   // Record kinds as they appear on out_kind
   localparam logic [KIND_W-1:0] KIND_REG  = 3'd0;
   localparam logic [KIND_W-1:0] KIND_LD   = 3'd1;
   localparam logic [KIND_W-1:0] KIND_STU  = 3'd2;
   localparam logic [KIND_W-1:0] KIND_ST   = 3'd3;
   localparam logic [KIND_W-1:0] KIND_NOP  = 3'd4;
   localparam logic [KIND_W-1:0] KIND_HALT = 3'd5;

   // Record layout, LSB first: mdata, addr, value, reg, pc, inum, kind.
   // inum width is a top-level parameter, so the kind offset is derived there.
   localparam int MDATA_LSB = 0;
   localparam int ADDR_LSB  = MDATA_LSB + DATA_W;
   localparam int VALUE_LSB = ADDR_LSB + DATA_W;
   localparam int REG_LSB   = VALUE_LSB + DATA_W;
   localparam int PC_LSB    = REG_LSB + REG_W;
   localparam int INUM_LSB  = PC_LSB + PC_W;

   // Tracer FSM states
   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Priority classifier: register writes dominate, then halt, then plain stores.
   function automatic logic [KIND_W-1:0] classify(input logic reg_wr,
                                                  input logic mem_rd,
                                                  input logic mem_wr,
                                                  input logic halt);
      logic [KIND_W-1:0] k;
      if (reg_wr && mem_wr) begin
         k = KIND_STU;
      end else if (reg_wr && mem_rd) begin
         k = KIND_LD;
      end else if (reg_wr) begin
         k = KIND_REG;
      end else if (halt) begin
         k = KIND_HALT;
      end else if (mem_wr) begin
         k = KIND_ST;
      end else begin
         k = KIND_NOP;
      end
      return k;
   endfunction

endpackage

// File: rtl/retire_trace_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy count. A write into a full FIFO is only
// taken when a read happens in the same cycle; a read of an empty FIFO is ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             do_wr;
   logic             do_rd;

   assign empty   = (count == {LW{1'b0}});
   assign full    = (count == LW'(DEPTH));
   assign do_rd   = rd_en && !empty;
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr];
   assign level   = count;

   // Storage write; contents need no reset since reads are gated by count.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= {AW{1'b0}};
         rd_ptr <= {AW{1'b0}};
         count  <= {LW{1'b0}};
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/retire_trace_fifo.sv
// Retirement tracer: classifies each retired instruction, numbers it and
// queues a trace record for a downstream consumer. After HALT retires the
// tracer stops accepting retires, drains, and then reports done.
module retire_trace_fifo
   import retire_trace_fifo_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CNT_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ret_valid,
   input  logic [15:0]              ret_pc,
   input  logic [15:0]              ret_inst,
   input  logic                     ret_reg_wr,
   input  logic [2:0]               ret_wr_reg,
   input  logic [15:0]              ret_wr_data,
   input  logic                     ret_mem_rd,
   input  logic                     ret_mem_wr,
   input  logic [15:0]              ret_mem_addr,
   input  logic [15:0]              ret_mem_data,
   input  logic                     ret_halt,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2:0]               out_kind,
   output logic [CNT_W-1:0]         out_inum,
   output logic [15:0]              out_pc,
   output logic [2:0]               out_reg,
   output logic [15:0]              out_value,
   output logic [15:0]              out_addr,
   output logic [15:0]              out_mdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic                     done,
   output logic [CNT_W-1:0]         cycle_count
);

   localparam int LVL_W    = $clog2(DEPTH) + 1;
   localparam int KIND_LSB = INUM_LSB + CNT_W;
   localparam int REC_W    = KIND_LSB + KIND_W;

   logic [1:0]        state;
   logic [CNT_W-1:0]  inst_cnt;
   logic [KIND_W-1:0] kind;
   logic [REG_W-1:0]  rec_reg;
   logic [DATA_W-1:0] rec_value;
   logic [DATA_W-1:0] rec_addr;
   logic [DATA_W-1:0] rec_mdata;
   logic [REC_W-1:0]  rec_in;
   logic [REC_W-1:0]  rec_head;
   logic [LVL_W-1:0]  fifo_level;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              unused_inst;

   // The instruction word is sampled at the boundary but not recorded.
   assign unused_inst = ^ret_inst;

   assign push = ret_valid && (state == ST_RUN);
   assign pop  = out_ready && !fifo_empty;
   assign kind = classify(ret_reg_wr, ret_mem_rd, ret_mem_wr, ret_halt);

   // Classifier: keep only the fields meaningful for this kind, zero the rest.
   always_comb begin
      rec_reg   = {REG_W{1'b0}};
      rec_value = {DATA_W{1'b0}};
      rec_addr  = {DATA_W{1'b0}};
      rec_mdata = {DATA_W{1'b0}};
      if (kind == KIND_REG || kind == KIND_LD || kind == KIND_STU) begin
         rec_reg   = ret_wr_reg;
         rec_value = ret_wr_data;
      end else begin
         rec_reg   = {REG_W{1'b0}};
         rec_value = {DATA_W{1'b0}};
      end
      if (kind == KIND_LD || kind == KIND_STU || kind == KIND_ST) begin
         rec_addr = ret_mem_addr;
      end else begin
         rec_addr = {DATA_W{1'b0}};
      end
      if (kind == KIND_STU || kind == KIND_ST) begin
         rec_mdata = ret_mem_data;
      end else begin
         rec_mdata = {DATA_W{1'b0}};
      end
   end

   assign rec_in = {kind, inst_cnt, ret_pc, rec_reg, rec_value, rec_addr, rec_mdata};

   sync_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (rec_in),
      .rd_en   (out_ready),
      .rd_data (rec_head),
      .level   (fifo_level),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Present the head record; an empty FIFO shows all-zero data.
   always_comb begin
      out_valid = !fifo_empty;
      out_kind  = {KIND_W{1'b0}};
      out_inum  = {CNT_W{1'b0}};
      out_pc    = {PC_W{1'b0}};
      out_reg   = {REG_W{1'b0}};
      out_value = {DATA_W{1'b0}};
      out_addr  = {DATA_W{1'b0}};
      out_mdata = {DATA_W{1'b0}};
      if (!fifo_empty) begin
         out_kind  = rec_head[KIND_LSB  +: KIND_W];
         out_inum  = rec_head[INUM_LSB  +: CNT_W];
         out_pc    = rec_head[PC_LSB    +: PC_W];
         out_reg   = rec_head[REG_LSB   +: REG_W];
         out_value = rec_head[VALUE_LSB +: DATA_W];
         out_addr  = rec_head[ADDR_LSB  +: DATA_W];
         out_mdata = rec_head[MDATA_LSB +: DATA_W];
      end else begin
         out_kind  = {KIND_W{1'b0}};
      end
   end

   assign level = fifo_level;
   assign done  = (state == ST_DONE);

   // Instruction numbering counts every accepted retire, including dropped ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_cnt <= {CNT_W{1'b0}};
      end else if (push) begin
         inst_cnt <= inst_cnt + CNT_W'(1);
      end else begin
         inst_cnt <= inst_cnt;
      end
   end

   // Free-running cycle counter since reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_count <= {CNT_W{1'b0}};
      end else begin
         cycle_count <= cycle_count + CNT_W'(1);
      end
   end

   // Sticky drop flag: a push into a full FIFO with no pop that cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (push && fifo_full && !pop) begin
         overflow <= 1'b1;
      end else begin
         overflow <= overflow;
      end
   end

   // Tracer FSM: stop at HALT (whether stored or dropped), then wait for empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_RUN;
      end else begin
         case (state)
            ST_RUN: begin
               if (push && kind == KIND_HALT) begin
                  state <= ST_DRAIN;
               end else begin
                  state <= ST_RUN;
               end
            end
            ST_DRAIN: begin
               if (fifo_level == {LVL_W{1'b0}}) begin
                  state <= ST_DONE;
               end else begin
                  state <= ST_DRAIN;
               end
            end
            ST_DONE: state <= ST_DONE;
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_retire_trace_fifo.sv
// Self-checking bench for retire_trace_fifo: a queue-based reference model is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_retire_trace_fifo;

   localparam int DEPTH = 16;
   localparam int CNT_W = 32;

   typedef struct {
      logic [2:0]  kind;
      logic [31:0] inum;
      logic [15:0] pc;
      logic [2:0]  rg;
      logic [15:0] value;
      logic [15:0] addr;
      logic [15:0] mdata;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ret_valid = 1'b0, ret_reg_wr = 1'b0, ret_mem_rd = 1'b0, ret_mem_wr = 1'b0, ret_halt = 1'b0;
   logic [15:0] ret_pc = 16'h0, ret_inst = 16'h0, ret_wr_data = 16'h0, ret_mem_addr = 16'h0, ret_mem_data = 16'h0;
   logic [2:0]  ret_wr_reg = 3'd0;
   logic        out_ready = 1'b1;
   logic        out_valid, overflow, done;
   logic [2:0]  out_kind, out_reg;
   logic [31:0] out_inum, cycle_count;
   logic [15:0] out_pc, out_value, out_addr, out_mdata;
   logic [4:0]  level;

   int n_cmp = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   rec_t        m_q[$];
   logic [31:0] m_cnt, m_cyc;
   bit          m_ovf, m_halted, m_done;

   retire_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_inst(ret_inst),
      .ret_reg_wr(ret_reg_wr), .ret_wr_reg(ret_wr_reg), .ret_wr_data(ret_wr_data),
      .ret_mem_rd(ret_mem_rd), .ret_mem_wr(ret_mem_wr), .ret_mem_addr(ret_mem_addr),
      .ret_mem_data(ret_mem_data), .ret_halt(ret_halt), .out_valid(out_valid),
      .out_ready(out_ready), .out_kind(out_kind), .out_inum(out_inum), .out_pc(out_pc),
      .out_reg(out_reg), .out_value(out_value), .out_addr(out_addr), .out_mdata(out_mdata),
      .level(level), .overflow(overflow), .done(done), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Build the record a retire must produce, straight from the kind rules.
   function automatic rec_t make_rec();
      rec_t r;
      r.inum = m_cnt; r.pc = ret_pc; r.rg = 3'd0; r.value = 16'h0;
      r.addr = 16'h0; r.mdata = 16'h0;
      if (ret_reg_wr) begin
         r.rg = ret_wr_reg; r.value = ret_wr_data;
         if (ret_mem_wr)      begin r.kind = 3'd2; r.addr = ret_mem_addr; r.mdata = ret_mem_data; end
         else if (ret_mem_rd) begin r.kind = 3'd1; r.addr = ret_mem_addr; end
         else                       r.kind = 3'd0;
      end else if (ret_halt) begin
         r.kind = 3'd5;
      end else if (ret_mem_wr) begin
         r.kind = 3'd3; r.addr = ret_mem_addr; r.mdata = ret_mem_data;
      end else begin
         r.kind = 3'd4;
      end
      return r;
   endfunction

   // Reference model: a queue of records updated at each clock edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q.delete();
         m_cnt <= 32'd0; m_cyc <= 32'd0; m_ovf <= 1'b0; m_halted <= 1'b0; m_done <= 1'b0;
      end else begin
         m_cyc <= m_cyc + 32'd1;
         if (m_halted && m_q.size() == 0) m_done <= 1'b1;
         if (out_ready && m_q.size() > 0) void'(m_q.pop_front());
         if (ret_valid && !m_halted) begin
            if (m_q.size() < DEPTH) m_q.push_back(make_rec());
            else                    m_ovf <= 1'b1;
            m_cnt <= m_cnt + 32'd1;
            if (make_rec().kind == 3'd5) m_halted <= 1'b1;
         end
      end
   end

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         rec_t h;
         h = '{3'd0, 32'd0, 16'h0, 3'd0, 16'h0, 16'h0, 16'h0};
         if (m_q.size() > 0) h = m_q[0];
         chk("m_valid", out_valid, m_q.size() > 0);
         chk("m_kind", out_kind, h.kind);
         chk("m_inum", out_inum, h.inum);
         chk("m_pc", out_pc, h.pc);
         chk("m_reg", out_reg, h.rg);
         chk("m_value", out_value, h.value);
         chk("m_addr", out_addr, h.addr);
         chk("m_mdata", out_mdata, h.mdata);
         chk("m_level", level, m_q.size());
         chk("m_overflow", overflow, m_ovf);
         chk("m_done", done, m_done);
         chk("m_cycle", cycle_count, m_cyc);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic retire(input logic [15:0] pc, input logic rw, input logic [2:0] wreg,
                         input logic [15:0] wdata, input logic mrd, input logic mwr,
                         input logic [15:0] addr, input logic [15:0] mdata, input logic halt);
      ret_valid = 1'b1; ret_pc = pc; ret_inst = pc ^ 16'h5A5A; ret_reg_wr = rw;
      ret_wr_reg = wreg; ret_wr_data = wdata; ret_mem_rd = mrd; ret_mem_wr = mwr;
      ret_mem_addr = addr; ret_mem_data = mdata; ret_halt = halt;
      tick();
      ret_valid = 1'b0; ret_reg_wr = 1'b0; ret_mem_rd = 1'b0; ret_mem_wr = 1'b0; ret_halt = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      tick();
      cmp_en = 1'b1;
      @(negedge clk);
      chk("rst_level", level, 5'd0);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_cycle", cycle_count, 32'd0);
      chk("rst_done", done, 1'b0);
      tick();
      rst = 1'b0;

      // Single register-write retire
      retire(16'h0002, 1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 16'h0077, 16'h0099, 1'b0);
      @(negedge clk);
      chk("t1_valid", out_valid, 1'b1);
      chk("t1_kind", out_kind, 3'd0);
      chk("t1_inum", out_inum, 32'd0);
      chk("t1_reg", out_reg, 3'd3);
      chk("t1_value", out_value, 16'h1234);
      chk("t1_addr", out_addr, 16'h0);
      chk("t1_mdata", out_mdata, 16'h0);

      // Load then plain store
      do_reset();
      out_ready = 1'b0;
      retire(16'h0004, 1'b1, 3'd1, 16'h0055, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);
      retire(16'h0006, 1'b0, 3'd2, 16'h7777, 1'b0, 1'b1, 16'h0042, 16'hBEEF, 1'b0);
      @(negedge clk);
      chk("t2_ld_kind", out_kind, 3'd1);
      chk("t2_ld_inum", out_inum, 32'd0);
      chk("t2_ld_addr", out_addr, 16'h0040);
      out_ready = 1'b1;
      @(negedge clk);
      chk("t2_st_kind", out_kind, 3'd3);
      chk("t2_st_inum", out_inum, 32'd1);
      chk("t2_st_reg", out_reg, 3'd0);
      chk("t2_st_value", out_value, 16'h0);
      chk("t2_st_mdata", out_mdata, 16'hBEEF);

      // Overflow with 20 retires into a 16-deep FIFO
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 20; i++)
         retire(16'(2 * i), 1'b1, 3'(i), 16'(i + 256), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
      chk("t3_level", level, 5'd16);
      chk("t3_overflow", overflow, 1'b1);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("t3_drain_inum", out_inum, 32'(i));
         @(negedge clk);
      end
      chk("t3_empty", level, 5'd0);
      retire(16'h0100, 1'b1, 3'd7, 16'hAAAA, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
      chk("t3_next_inum", out_inum, 32'd20);

      // Full FIFO with simultaneous push and pop
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++)
         retire(16'(i), 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 16'(i), 16'(i * 3), 1'b0);
      @(negedge clk);
      chk("t4_full_level", level, 5'd16);
      out_ready = 1'b1;
      retire(16'h0020, 1'b1, 3'd2, 16'h2222, 1'b0, 1'b1, 16'h0300, 16'h4444, 1'b0);
      @(negedge clk);
      chk("t4_level", level, 5'd16);
      chk("t4_overflow", overflow, 1'b0);

      // NOP, HALT, then ignored retires and drain to done
      do_reset();
      out_ready = 1'b0;
      retire(16'h000E, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      retire(16'h0010, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
      retire(16'h0012, 1'b1, 3'd4, 16'h0BAD, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      retire(16'h0014, 1'b1, 3'd5, 16'h0BAD, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
      chk("t5_level", level, 5'd2);
      chk("t5_nop_kind", out_kind, 3'd4);
      out_ready = 1'b1;
      @(negedge clk);
      chk("t5_halt_kind", out_kind, 3'd5);
      chk("t5_halt_inum", out_inum, 32'd1);
      chk("t5_halt_pc", out_pc, 16'h0010);
      @(negedge clk);
      chk("t5_drained", out_valid, 1'b0);
      chk("t5_done_early", done, 1'b0);
      @(negedge clk);
      chk("t5_done", done, 1'b1);
      retire(16'h0016, 1'b1, 3'd1, 16'h1111, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
      chk("t5_ignored", level, 5'd0);

      // Reset mid-drain
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         retire(16'(i), 1'b1, 3'(i), 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      retire(16'h0030, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
      @(negedge clk);
      chk("t6_level5", level, 5'd5);
      #2 rst = 1'b1;
      #1;
      chk("t6_level", level, 5'd0);
      chk("t6_valid", out_valid, 1'b0);
      chk("t6_done", done, 1'b0);
      chk("t6_cycle", cycle_count, 32'd0);
      tick();
      rst = 1'b0;
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
